ahb_arbiter: RTL and testbench

Round-robin bus arbiter that shares one AHB address/data path between up to eight masters. It drives the one-hot grant vector and the address-phase owner index, `HMASTER`, which the master-side address/write-data muxes and the slave decoder use. It rotates ownership only at burst boundaries and enforces a per-owner tenure limit. When no master requests, it parks the bus on a default master.

---
 rtl/ahb_arbiter.sv | 144 ++++++++++++++
 tb/tb_ahb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB bus arbiter for up to eight masters.
// Ownership rotates only at burst boundaries (IDLE/NONSEQ edges). An owner
// may keep the bus for at most MAX_TENURE beats while others are waiting.
// With no requests, the bus is parked on DEFAULT_MASTER.
// Optional feature macro: AHB_ARB_LOCK_EN adds the LOCKED state, honours
// HLOCK, and drives HMASTLOCK. Without the macro, HLOCK is ignored and
// HMASTLOCK is 0.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [2:0]             HMASTER,
    output logic                   HMASTLOCK
);

    localparam int                     IDX_W        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [IDX_W-1:0]       DEF_IDX      = IDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH       = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [7:0]             TENURE_LIMIT = 8'(MAX_TENURE);
    localparam logic [1:0]             HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]             HTRANS_NONSEQ = 2'b10;

`ifdef AHB_ARB_LOCK_EN
    typedef enum logic [1:0] {ST_PARK, ST_OWN, ST_LOCKED} state_e;
`else
    typedef enum logic [1:0] {ST_PARK, ST_OWN} state_e;
`endif

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [IDX_W-1:0]       hmaster_q;
    logic                   hmastlock_q;
    logic [7:0]             tenure_cnt_q, tenure_cnt_d;

    logic [IDX_W-1:0]       sel_idx, cand_idx;
    logic                   sel_found;
    logic                   boundary, beat, own_req, others_req, any_req;
    logic                   tenure_hit, lock_cur, arb_point;

    // Qualifiers for the bus state seen at this edge
    assign boundary   = (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ);
    assign beat       = HTRANS[1];
    assign own_req    = |(HBUSREQ & hgrant_q);
    assign others_req = |(HBUSREQ & ~hgrant_q);
    assign any_req    = |HBUSREQ;
    assign tenure_hit = (tenure_cnt_q >= TENURE_LIMIT);

`ifdef AHB_ARB_LOCK_EN
    assign lock_cur = HLOCK[grant_idx_q];
`else
    logic hlock_unused;
    assign hlock_unused = ^HLOCK;
    assign lock_cur     = 1'b0;
`endif

    // Round-robin search starting after the current owner; owner is checked last
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        sel_idx   = DEF_IDX;
        sel_found = 1'b0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand_idx = IDX_W'((int'(grant_idx_q) + k) % NUM_MASTERS);
            if (!sel_found && HBUSREQ[cand_idx]) begin
                sel_idx   = cand_idx;
                sel_found = 1'b1;
            end
        end
    end

    // Arbitration decision, next owner, next state and next tenure count
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        arb_point   = 1'b0;
        case (state_q)
            ST_PARK: arb_point = boundary;
            ST_OWN: begin
`ifdef AHB_ARB_LOCK_EN
                if (lock_cur)
                    state_d = ST_LOCKED;
                else
`endif
                    arb_point = boundary && (!own_req || (tenure_hit && others_req));
            end
`ifdef AHB_ARB_LOCK_EN
            ST_LOCKED: begin
                if (boundary && !lock_cur)
                    state_d = ST_OWN;
            end
`endif
            default: state_d = ST_PARK;
        endcase

        if (arb_point) begin
            grant_idx_d = sel_idx;
            state_d     = any_req ? ST_OWN : ST_PARK;
        end

        if (grant_idx_d != grant_idx_q)
            tenure_cnt_d = 8'd0;
        else if (beat && (tenure_cnt_q != 8'hFF))
            tenure_cnt_d = tenure_cnt_q + 8'd1;
        else
            tenure_cnt_d = tenure_cnt_q;

        hgrant_d              = '0;
        hgrant_d[grant_idx_d] = 1'b1;
    end

    // Registered FSM and outputs; everything freezes while HREADY is low
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_PARK;
            grant_idx_q  <= DEF_IDX;
            hgrant_q     <= DEF_OH;
            hmaster_q    <= DEF_IDX;
            hmastlock_q  <= 1'b0;
            tenure_cnt_q <= 8'd0;
        end else if (HREADY) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            hgrant_q     <= hgrant_d;
            hmaster_q    <= grant_idx_q;
            hmastlock_q  <= lock_cur;
            tenure_cnt_q <= tenure_cnt_d;
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = 3'(hmaster_q);
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed stimulus for ahb_arbiter (4 masters, default 0,
// tenure limit 4). A behavioural model, stepped on every clock edge, holds
// the expected owner, address-phase owner and lock flag. A compare process
// checks the DUT against the model on each falling edge. Literal checks
// pin the model at key points.
module tb_ahb_arbiter;

    localparam int N    = 4;
    localparam int DEF  = 0;
    localparam int MAXT = 4;
`ifdef AHB_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic         HCLK;
    logic         HRESETn;
    logic [N-1:0] HBUSREQ;
    logic [N-1:0] HLOCK;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic [N-1:0] HGRANT;
    logic [2:0]   HMASTER;
    logic         HMASTLOCK;

    int n_checks = 0;
    int n_errors = 0;

    ahb_arbiter #(
        .NUM_MASTERS   (N),
        .DEFAULT_MASTER(DEF),
        .MAX_TENURE    (MAXT)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Model state: granted index, address-phase owner, lock flag, beats held
    // by the current grant, and mode (0 parked, 1 owned, 2 locked).
    int m_grant  = DEF;
    int m_master = DEF;
    int m_cnt    = 0;
    int m_mode   = 0;
    bit m_lock   = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int rr_pick(input int cur, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++)
            if (req[(cur + k) % N]) return (cur + k) % N;
        return DEF;
    endfunction

    task automatic model_reset();
        m_grant  = DEF;
        m_master = DEF;
        m_cnt    = 0;
        m_mode   = 0;
        m_lock   = 1'b0;
    endtask

    task automatic model_step();
        int  nxt_grant;
        int  nxt_mode;
        bit  between;
        bit  held;
        bit  competing;
        if (!HREADY) return;
        between   = (HTRANS == IDLE) || (HTRANS == NONSEQ);
        held      = LOCK_EN && HLOCK[m_grant];
        competing = 1'b0;
        for (int i = 0; i < N; i++)
            if (i != m_grant && HBUSREQ[i]) competing = 1'b1;
        nxt_grant = m_grant;
        nxt_mode  = m_mode;
        if (m_mode == 2) begin
            if (between && !held) nxt_mode = 1;
        end else if (m_mode == 1 && held) begin
            nxt_mode = 2;
        end else if (between && (m_mode == 0 || !HBUSREQ[m_grant] ||
                                 (m_cnt >= MAXT && competing))) begin
            nxt_grant = rr_pick(m_grant, HBUSREQ);
            nxt_mode  = (HBUSREQ != 0) ? 1 : 0;
        end
        m_master = m_grant;
        m_lock   = held;
        if (nxt_grant != m_grant) m_cnt = 0;
        else if (HTRANS[1] && m_cnt < 255) m_cnt++;
        m_grant = nxt_grant;
        m_mode  = nxt_mode;
    endtask

    // Apply one set of inputs across one rising edge
    task automatic drive(input logic [N-1:0] req, input logic [1:0] tr,
                         input logic rdy, input logic [N-1:0] lk);
        HBUSREQ = req;
        HTRANS  = tr;
        HREADY  = rdy;
        HLOCK   = lk;
        @(posedge HCLK);
        model_step();
        #1;
    endtask

    // Compare DUT against the model on every falling edge out of reset
    initial begin
        forever begin
            @(negedge HCLK);
            if (HRESETn) begin
                check("model_hgrant", int'(HGRANT), 1 << m_grant);
                check("model_hmaster", int'(HMASTER), m_master);
                check("model_hmastlock", int'(HMASTLOCK), int'(m_lock));
            end
        end
    end

    initial begin
        HRESETn = 1'b1;
        HBUSREQ = '0;
        HLOCK   = '0;
        HTRANS  = IDLE;
        HREADY  = 1'b1;
        #1 HRESETn = 1'b0;
        model_reset();
        #21 HRESETn = 1'b1;
        check("reset_hgrant", int'(HGRANT), 4'b0001);
        check("reset_hmaster", int'(HMASTER), 0);
        check("reset_hmastlock", int'(HMASTLOCK), 0);

        // Single request from master 2
        drive(4'b0100, IDLE, 1'b1, 4'b0000);
        check("single_hgrant", int'(HGRANT), 4'b0100);
        check("single_hmaster_lag", int'(HMASTER), 0);
        drive(4'b0100, IDLE, 1'b1, 4'b0000);
        check("single_hmaster", int'(HMASTER), 2);

        // Request released: park back on the default master
        drive(4'b0000, IDLE, 1'b1, 4'b0000);
        check("park_hgrant", int'(HGRANT), 4'b0001);

        // Fairness: all masters request, continuous NONSEQ
        for (int e = 1; e <= 21; e++) begin
            drive(4'b1111, NONSEQ, 1'b1, 4'b0000);
            case (e)
                1:  check("fair_e1", int'(HGRANT), 4'b0010);
                5:  check("fair_e5_hold", int'(HGRANT), 4'b0010);
                6:  check("fair_e6", int'(HGRANT), 4'b0100);
                11: check("fair_e11", int'(HGRANT), 4'b1000);
                16: check("fair_e16", int'(HGRANT), 4'b0001);
                21: check("fair_e21", int'(HGRANT), 4'b0010);
                default: ;
            endcase
        end

        // Burst protection: owner 1 drops its request after the first beat
        drive(4'b1010, NONSEQ, 1'b1, 4'b0000);
        for (int b = 0; b < 3; b++) begin
            drive(4'b1000, SEQ, 1'b1, 4'b0000);
            check("burst_hold", int'(HGRANT), 4'b0010);
        end
        drive(4'b1000, IDLE, 1'b1, 4'b0000);
        check("burst_end_hgrant", int'(HGRANT), 4'b1000);
        check("burst_end_hmaster", int'(HMASTER), 1);

        // Wait states: three HREADY=0 edges freeze everything
        for (int w = 0; w < 3; w++) begin
            drive(4'b0001, IDLE, 1'b0, 4'b0000);
            check("wait_hgrant", int'(HGRANT), 4'b1000);
            check("wait_hmaster", int'(HMASTER), 1);
        end
        drive(4'b0001, IDLE, 1'b1, 4'b0000);
        check("wait_done_hgrant", int'(HGRANT), 4'b0001);
        check("wait_done_hmaster", int'(HMASTER), 3);
        drive(4'b0001, IDLE, 1'b1, 4'b0000);
        check("wait_next_hmaster", int'(HMASTER), 0);

        // Lock: master 2 locks over 20 NONSEQ beats while master 0 requests
        drive(4'b0100, IDLE, 1'b1, 4'b0100);
        check("lock_grant2", int'(HGRANT), 4'b0100);
        for (int e = 1; e <= 20; e++) begin
            drive(4'b0101, NONSEQ, 1'b1, 4'b0100);
`ifdef AHB_ARB_LOCK_EN
            if (e == 1 || e == 20) begin
                check("lock_hold_hgrant", int'(HGRANT), 4'b0100);
                check("lock_hmastlock", int'(HMASTLOCK), 1);
            end
`else
            if (e == 4) check("nolock_e4", int'(HGRANT), 4'b0100);
            if (e == 5) check("nolock_e5", int'(HGRANT), 4'b0001);
            if (e == 20) check("nolock_hmastlock", int'(HMASTLOCK), 0);
`endif
        end
        drive(4'b0101, NONSEQ, 1'b1, 4'b0000);
        drive(4'b0101, NONSEQ, 1'b1, 4'b0000);
`ifdef AHB_ARB_LOCK_EN
        check("unlock_hgrant", int'(HGRANT), 4'b0001);
`else
        check("nolock_after_hgrant", int'(HGRANT), 4'b0100);
`endif

        // Reset in the middle of a burst owned by master 1
        drive(4'b0010, IDLE, 1'b1, 4'b0000);
        check("pre_reset_hgrant", int'(HGRANT), 4'b0010);
        drive(4'b0010, NONSEQ, 1'b1, 4'b0000);
        drive(4'b0010, SEQ, 1'b1, 4'b0000);
        check("pre_reset_hmaster", int'(HMASTER), 1);
        HTRANS = SEQ;
        #2 HRESETn = 1'b0;
        model_reset();
        #1;
        check("midreset_hgrant", int'(HGRANT), 4'b0001);
        check("midreset_hmaster", int'(HMASTER), 0);
        check("midreset_hmastlock", int'(HMASTLOCK), 0);
        #2 HRESETn = 1'b1;
        drive(4'b0000, IDLE, 1'b1, 4'b0000);
        drive(4'b0000, IDLE, 1'b1, 4'b0000);
        check("post_reset_hgrant", int'(HGRANT), 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
